// File: rtl/ant_buf_wr_pkg.sv
// Shared defaults and helpers for the antenna frame buffer.
package ant_buf_wr_pkg;

  localparam int DEF_N_ANTS = 16;
  localparam int DEF_DATA_W = 8;

  // Ceiling log2; log2(1) = 0.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ant_buf_wr_ram.sv
// One write port, two registered read ports, read-first on collisions.
module ant_buf_ram
  import ant_buf_wr_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              sync,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] dout_a_p1;
  logic [DATA_W-1:0] dout_b_p1;

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read stage p0 -> p1: registered outputs see pre-write contents.
  always_ff @(posedge clk) begin
    if (sync) begin
      dout_a_p1 <= '0;
      dout_b_p1 <= '0;
    end else begin
      dout_a_p1 <= mem[raddr_a];
      dout_b_p1 <= mem[raddr_b];
    end
  end

  assign rdata_a = dout_a_p1;
  assign rdata_b = dout_b_p1;

endmodule

// File: rtl/ant_buf_wr.sv
// Double-buffered antenna frame writer: fills alternate banks with
// N_ANTS-sample frames, tracks full banks and drops frames on overrun.
module ant_buf_wr
  import ant_buf_wr_pkg::*;
#(
  parameter int   N_ANTS   = DEF_N_ANTS,
  parameter int   DATA_W   = DEF_DATA_W,
  localparam int  ANT_BITS = log2(N_ANTS)
) (
  input  logic                clk,
  input  logic                sync,
  input  logic [DATA_W-1:0]   din,
  input  logic                din_valid,
  input  logic [ANT_BITS-1:0] rd_ant_a,
  input  logic [ANT_BITS-1:0] rd_ant_b,
  input  logic                rd_sel_a,
  input  logic                rd_sel_b,
  input  logic                rd_release,
  input  logic                rd_release_bank,
  output logic [DATA_W-1:0]   dout_a,
  output logic [DATA_W-1:0]   dout_b,
  output logic [1:0]          bank_full,
  output logic                wr_bank,
  output logic                frame_done,
  output logic                overrun
);

  logic [ANT_BITS-1:0] wr_ant;
  logic                frame_drop;

  logic                first;
  logic                drop_first;
  logic                drop_now;
  logic                frame_end;
  logic                commit;
  logic                we;
  logic [1:0]          set_mask;
  logic [1:0]          clr_mask;
  logic [1:0]          bank_full_nxt;

  // Drop decision, frame completion and full-flag update (set beats clear).
  always_comb begin
    first         = (wr_ant == '0);
    drop_first    = bank_full[wr_bank] &
                    ~(rd_release & (rd_release_bank == wr_bank));
    drop_now      = first ? drop_first : frame_drop;
    frame_end     = din_valid & (wr_ant == ANT_BITS'(N_ANTS - 1));
    commit        = frame_end & ~drop_now;
    we            = din_valid & ~sync & ~drop_now;
    set_mask      = 2'b00;
    clr_mask      = 2'b00;
    if (commit)     set_mask[wr_bank]         = 1'b1;
    if (rd_release) clr_mask[rd_release_bank] = 1'b1;
    bank_full_nxt = (bank_full & ~clr_mask) | set_mask;
  end

  // Control state: write pointer, bank select, flags.
  always_ff @(posedge clk) begin
    if (sync) begin
      wr_ant     <= '0;
      wr_bank    <= 1'b0;
      bank_full  <= 2'b00;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      frame_done <= commit;
      bank_full  <= bank_full_nxt;
      if (din_valid) begin
        wr_ant <= wr_ant + ANT_BITS'(1);
        if (first) frame_drop <= drop_first;
      end
      if (commit) wr_bank <= ~wr_bank;
      if (frame_end & drop_now) overrun <= 1'b1;
    end
  end

  ant_buf_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ANT_BITS + 1)
  ) u_ram (
    .clk     (clk),
    .sync    (sync),
    .we      (we),
    .waddr   ({wr_bank, wr_ant}),
    .wdata   (din),
    .raddr_a ({rd_sel_a, rd_ant_a}),
    .raddr_b ({rd_sel_b, rd_ant_b}),
    .rdata_a (dout_a),
    .rdata_b (dout_b)
  );

endmodule
